prgrom_upg_ctrl: RTL and testbench
==================================

# prgrom_upg_ctrl

Upgrade sequencer for the instruction memory. It receives a length-prefixed little-endian byte stream from the UART receiver over a valid/ready handshake and assembles 32-bit words. It then drives the program ROM's upgrade write port and holds the CPU while loading. It signals completion so the ROM port can switch back to CPU fetch.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the program ROM upgrade port
- MAX_WORDS, 16384, largest accepted image in words (must be ≤ 2^ADDR_W)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle request to begin an upgrade
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o at clock edge
- upg_wen_o  out  1  one-cycle write strobe to ROM upgrade port
- upg_adr_o  out  ADDR_W  word address of current write
- upg_dat_o  out  32  word being written
- upg_done_o  out  1  sticky: image fully loaded
- cpu_hold_o  out  1  high while the upgrade is in progress or has failed
- err_o  out  1  sticky: bad header (or checksum, see Configuration)

## Operation
- States: IDLE, HDR, DATA, WRITE, CHK (only with macro), DONE, ERR.
- IDLE: rx_ready_o=0, cpu_hold_o=0. On start_i, go to HDR. Clear upg_done_o and err_o, clear the word index, set cpu_hold_o=1.
- HDR: rx_ready_o=1. Accept 2 bytes forming word count N, low byte first.
  - If N==0 or N>MAX_WORDS, go to ERR.
  - Otherwise go to DATA.
- DATA: rx_ready_o=1. Accept 4 bytes, little-endian (first byte into bits 7:0). After the 4th byte, go to WRITE.
- WRITE: rx_ready_o=0. Assert upg_wen_o=1 for exactly one cycle with upg_adr_o=index and upg_dat_o=assembled word. Then increment the index.
  - If the new index==N, go to CHK (macro) or DONE.
  - Otherwise go back to DATA.
- DONE: upg_done_o=1, cpu_hold_o=0. Go to IDLE on the next cycle; upg_done_o stays high until the next start_i or reset.
- ERR: err_o=1, cpu_hold_o=1, rx_ready_o=0. Leave only on start_i (back to HDR, flags cleared) or on reset.
- start_i in any state other than IDLE or ERR is ignored.
- Bytes presented while rx_ready_o=0 are not consumed; the source must hold them.
- The index is ADDR_W+1 bits wide so that MAX_WORDS compares without wrap.

## Timing
- Reset values: state IDLE. All outputs 0, including upg_adr_o, upg_dat_o, upg_done_o, err_o and cpu_hold_o.
- Write latency: upg_wen_o is high in the cycle after the 4th byte of a word is accepted.
- upg_adr_o and upg_dat_o are registered and stable for the whole upg_wen_o cycle.
- Peak throughput: 5 cycles per word (4 byte accepts plus 1 write bubble).
- upg_done_o rises in the cycle after the last write (or after CHK).
- cpu_hold_o rises in the cycle after start_i.
- Reset mid-load: everything returns to reset values immediately. The partial image is not invalidated; the CPU stays released, since cpu_hold_o=0 after reset.

## Configuration
- Macro PRGROM_UPG_CHECKSUM_EN.
- Defined:
  - Keep a running 8-bit sum (mod 256) of all data bytes; header bytes are excluded.
  - After the last write, go to CHK and accept 1 trailing byte.
  - If it equals the sum, go to DONE; otherwise go to ERR. Words already written remain written.
- Undefined: no CHK state and no trailing byte; go from the last WRITE directly to DONE.

## Structure
- Package prgrom_upg_pkg: state enum, BYTES_PER_WORD=4, HDR_BYTES=2, default ADDR_W.
- Sub-module upg_byte_packer: byte counter plus little-endian shift into a 32-bit word, with a word_ready pulse. The FSM lives in the top module.

## Test plan
- Single word: after start_i, send 01 00 78 56 34 12 → one upg_wen_o pulse, adr=0, dat=0x12345678. upg_done_o=1, cpu_hold_o=0.
- Three words with rx_valid_i toggled randomly → writes at adr 0,1,2 with correct data, each wen exactly one cycle; no byte is lost or duplicated.
- Header 00 00 → err_o=1, no writes, cpu_hold_o stays 1. A new start_i then a valid image → err_o clears, upg_done_o=1.
- rst_i asserted after 2 of 4 words → all outputs 0 next cycle. A following start_i restarts from adr 0.
- With PRGROM_UPG_CHECKSUM_EN: 1 word of 01 02 03 04, trailer 0x0A → upg_done_o=1. Trailer 0x0B → err_o=1 after the write.
- start_i pulsed during DATA → ignored; the sequence completes normally.

Source files
------------

// File: rtl/prgrom_upg_pkg.sv
// Shared types and constants for the program ROM upgrade sequencer.
package prgrom_upg_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int DEFAULT_ADDR_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } upg_state_e;

  // Running modulo-256 byte sum used for the optional image checksum.
  function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/upg_byte_packer.sv
// Little-endian byte packer: shifts accepted bytes into a 32-bit word and
// flags the byte that completes a word. word_next is the word as it stands
// once the current byte is included, so the caller can register it directly.
module upg_byte_packer
  import prgrom_upg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [31:0] word_r;

  // New bytes enter at the top so the first byte ends up in bits 7:0.
  always_comb begin
    word_next  = {byte_in, word_r[31:8]};
    word_ready = byte_en && (cnt_r == LAST_BYTE);
  end

  // Byte counter and shift register; clr realigns to a word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (clr) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (byte_en) begin
      cnt_r  <= cnt_r + 2'd1;
      word_r <= word_next;
    end else begin
      cnt_r  <= cnt_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/prgrom_upg_ctrl.sv
// Program ROM upgrade sequencer. Takes a length-prefixed little-endian byte
// stream (2-byte word count, then 4 bytes per word), writes each word to the
// ROM upgrade port and holds the CPU while loading.
// Optional macro PRGROM_UPG_CHECKSUM_EN: a trailing byte must equal the
// modulo-256 sum of all data bytes, otherwise the load ends in error.
module prgrom_upg_ctrl
  import prgrom_upg_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_hold_o,
  output logic              err_o
);

  // One extra index bit so an image of exactly 2^ADDR_W words compares cleanly.
  localparam int          CNT_W       = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);
  localparam logic        HDR_LAST    = 1'(HDR_BYTES - 1);

  upg_state_e        state_r;
  logic              rx_ready_r;
  logic              upg_wen_r;
  logic [ADDR_W-1:0] upg_adr_r;
  logic [31:0]       upg_dat_r;
  logic              upg_done_r;
  logic              cpu_hold_r;
  logic              err_r;
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  n_r;
  logic              hdr_cnt_r;
  logic [7:0]        hdr_lo_r;
`ifdef PRGROM_UPG_CHECKSUM_EN
  logic [7:0]        sum_r;
`endif

  logic              accept_s;
  logic              start_ok_s;
  logic              data_en_s;
  logic              word_ready_s;
  logic [31:0]       word_next_s;
  logic [15:0]       n_hdr_s;
  logic              hdr_bad_s;
  logic [CNT_W-1:0]  idx_next_s;

  // Handshake, start qualification and header decode.
  always_comb begin
    accept_s   = rx_valid_i && rx_ready_r;
    start_ok_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    data_en_s  = accept_s && (state_r == ST_DATA);
    n_hdr_s    = {rx_data_i, hdr_lo_r};
    hdr_bad_s  = (n_hdr_s == 16'd0) || ({1'b0, n_hdr_s} > MAX_WORDS_L);
    idx_next_s = idx_r + CNT_W'(1'b1);
  end

  upg_byte_packer u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (start_ok_s),
    .byte_en    (data_en_s),
    .byte_in    (rx_data_i),
    .word_next  (word_next_s),
    .word_ready (word_ready_s)
  );

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      rx_ready_r <= 1'b0;
      upg_wen_r  <= 1'b0;
      upg_adr_r  <= '0;
      upg_dat_r  <= 32'd0;
      upg_done_r <= 1'b0;
      cpu_hold_r <= 1'b0;
      err_r      <= 1'b0;
      idx_r      <= '0;
      n_r        <= '0;
      hdr_cnt_r  <= 1'b0;
      hdr_lo_r   <= 8'd0;
`ifdef PRGROM_UPG_CHECKSUM_EN
      sum_r      <= 8'd0;
`endif
    end else begin
      upg_wen_r <= 1'b0;
      if (start_ok_s) begin
        state_r    <= ST_HDR;
        rx_ready_r <= 1'b1;
        upg_done_r <= 1'b0;
        err_r      <= 1'b0;
        cpu_hold_r <= 1'b1;
        idx_r      <= '0;
        hdr_cnt_r  <= 1'b0;
`ifdef PRGROM_UPG_CHECKSUM_EN
        sum_r      <= 8'd0;
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            rx_ready_r <= 1'b0;
            cpu_hold_r <= 1'b0;
          end
          ST_HDR: begin
            if (accept_s) begin
              if (hdr_cnt_r != HDR_LAST) begin
                hdr_lo_r  <= rx_data_i;
                hdr_cnt_r <= 1'b1;
              end else if (hdr_bad_s) begin
                state_r    <= ST_ERR;
                rx_ready_r <= 1'b0;
                err_r      <= 1'b1;
              end else begin
                state_r <= ST_DATA;
                n_r     <= CNT_W'(n_hdr_s);
              end
            end
          end
          ST_DATA: begin
            if (accept_s) begin
`ifdef PRGROM_UPG_CHECKSUM_EN
              sum_r <= sum8_add(sum_r, rx_data_i);
`endif
              if (word_ready_s) begin
                state_r    <= ST_WRITE;
                rx_ready_r <= 1'b0;
                upg_wen_r  <= 1'b1;
                upg_adr_r  <= idx_r[ADDR_W-1:0];
                upg_dat_r  <= word_next_s;
              end
            end
          end
          ST_WRITE: begin
            idx_r <= idx_next_s;
            if (idx_next_s == n_r) begin
`ifdef PRGROM_UPG_CHECKSUM_EN
              state_r    <= ST_CHK;
              rx_ready_r <= 1'b1;
`else
              state_r    <= ST_DONE;
              upg_done_r <= 1'b1;
              cpu_hold_r <= 1'b0;
`endif
            end else begin
              state_r    <= ST_DATA;
              rx_ready_r <= 1'b1;
            end
          end
`ifdef PRGROM_UPG_CHECKSUM_EN
          ST_CHK: begin
            if (accept_s) begin
              rx_ready_r <= 1'b0;
              if (rx_data_i == sum_r) begin
                state_r    <= ST_DONE;
                upg_done_r <= 1'b1;
                cpu_hold_r <= 1'b0;
              end else begin
                state_r <= ST_ERR;
                err_r   <= 1'b1;
              end
            end
          end
`endif
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          ST_ERR: begin
            rx_ready_r <= 1'b0;
            cpu_hold_r <= 1'b1;
            err_r      <= 1'b1;
          end
          default: begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            cpu_hold_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_ready_o = rx_ready_r;
  assign upg_wen_o  = upg_wen_r;
  assign upg_adr_o  = upg_adr_r;
  assign upg_dat_o  = upg_dat_r;
  assign upg_done_o = upg_done_r;
  assign cpu_hold_o = cpu_hold_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_prgrom_upg_ctrl.sv
// Self-checking bench for prgrom_upg_ctrl: table of images plus hand-written
// reset-mid-load and start-during-DATA sequences; writes checked via a queue.
module tb_prgrom_upg_ctrl;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 16384;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [7:0]        rx_data_i = 8'd0;
  logic              rx_valid_i = 1'b0;
  logic              rx_ready_o;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              cpu_hold_o;
  logic              err_o;

  always #5 clk = ~clk;

  prgrom_upg_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .cpu_hold_o (cpu_hold_o),
    .err_o      (err_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [15:0]      n;
    int               nw;
    logic [2:0][31:0] w;
    bit               gaps;
    bit               bad_trl;
    bit               exp_done;
  } vec_t;
  vec_t vecs[$];

  logic [ADDR_W-1:0] exp_adr;
  logic [7:0]        sum_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the queue and last one cycle.
  initial begin
    wr_t e;
    logic prev_wen;
    prev_wen = 1'b0;
    forever begin
      @(negedge clk);
      if (upg_wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {18'd0, upg_adr_o, upg_dat_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_adr_dat", {18'd0, upg_adr_o, upg_dat_o}, {18'd0, e.adr, e.dat});
        end
        chk("wen_one_cycle", {63'd0, prev_wen}, 64'd0);
      end
      prev_wen = (upg_wen_o === 1'b1);
    end
  end

  function automatic vec_t mk(input logic [15:0] n, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input bit gaps,
                              input bit bad_trl, input bit exp_done);
    vec_t v;
    v.n = n; v.nw = nw; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.gaps = gaps; v.bad_trl = bad_trl; v.exp_done = exp_done;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      rx_valid_i = 1'b0;
      rx_data_i  = 8'hXX;
      @(negedge clk);
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    while ((rx_ready_o !== 1'b1) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [7:0] b;
    exp_q.push_back('{exp_adr, w});
    exp_adr = exp_adr + 14'd1;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      sum_m = sum_m + b;
      send_byte(b, gaps);
    end
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_adr = '0;
    sum_m   = 8'd0;
    chk("start_hold", {63'd0, cpu_hold_o}, 64'd1);
    chk("start_flags_clear", {62'd0, upg_done_o, err_o}, 64'd0);
    chk("start_rx_ready", {63'd0, rx_ready_o}, 64'd1);
  endtask

  task automatic send_trailer(input bit bad);
`ifdef PRGROM_UPG_CHECKSUM_EN
    send_byte(bad ? (sum_m + 8'd1) : sum_m, 1'b0);
`else
    if (bad) $display("note: trailer requested without checksum build");
`endif
  endtask

  task automatic wait_end(input bit exp_done);
    int n;
    n = 0;
    while (!((upg_done_o === 1'b1) || (err_o === 1'b1)) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    chk("end_done", {63'd0, upg_done_o}, {63'd0, exp_done});
    chk("end_err", {63'd0, err_o}, {63'd0, !exp_done});
    chk("end_hold", {63'd0, cpu_hold_o}, {63'd0, !exp_done});
    chk("end_rx_ready", {63'd0, rx_ready_o}, 64'd0);
    repeat (3) @(negedge clk);
    chk("sticky_flags", {62'd0, upg_done_o, err_o}, {62'd0, exp_done, !exp_done});
    chk("sticky_hold", {63'd0, cpu_hold_o}, {63'd0, !exp_done});
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t v;
    exp_adr = '0;
    sum_m   = 8'd0;

    vecs.push_back(mk(16'd1,      1, 32'h12345678, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(16'd3,      3, 32'hDEADBEEF, 32'h00000001, 32'hA5C3F00F, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(16'd0,      0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(16'd2,      2, 32'h89ABCDEF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(16'h4001,   0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFF,   0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(16'd1,      1, 32'h04030201, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
`ifdef PRGROM_UPG_CHECKSUM_EN
    vecs.push_back(mk(16'd1,      1, 32'h04030201, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {9'd0, rx_ready_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, cpu_hold_o, err_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_no_hold", {62'd0, cpu_hold_o, rx_ready_o}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start_pulse();
      send_byte(v.n[7:0], v.gaps);
      send_byte(v.n[15:8], v.gaps);
      for (int k = 0; k < v.nw; k++) send_word(v.w[k], v.gaps);
      if (v.nw > 0) send_trailer(v.bad_trl);
      wait_end(v.exp_done);
    end

    // Reset after 2 of 4 words, then a fresh load must restart at address 0.
    start_pulse();
    send_byte(8'd4, 1'b0);
    send_byte(8'd0, 1'b0);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midload_reset", {9'd0, rx_ready_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, cpu_hold_o, err_o}, 64'd0);
    chk("midload_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    start_pulse();
    send_byte(8'd1, 1'b0);
    send_byte(8'd0, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_trailer(1'b0);
    wait_end(1'b1);

    // start_i in DATA must not restart the sequence.
    start_pulse();
    send_byte(8'd1, 1'b0);
    send_byte(8'd0, 1'b0);
    exp_q.push_back('{exp_adr, 32'hCAFEF00D});
    sum_m = sum_m + 8'h0D + 8'hF0 + 8'hFE + 8'hCA;
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_in_data_hold", {62'd0, cpu_hold_o, rx_ready_o}, 64'd3);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
    send_trailer(1'b0);
    wait_end(1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
